register_tree_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one `register_tree` replace-top port among `NUM_REQ` requesters. Each granted request pops the current maximum (`top_item`) and returns it to the requester, while the requester's item is pushed in its place. The block sits directly in front of `register_tree`:
- It enforces the tree's post-reset initialisation time.
- It enforces the settle time between replaces, so `top_item` is always sampled only when valid.

---
 rtl/register_tree_arbiter.sv | 151 +++++++++++++++
 tb/tb_register_tree_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/register_tree_arbiter.sv
// Round-robin arbiter and sequencer in front of a register_tree replace-top port.
// Each grant pops the current tree top back to the requester and pushes the
// requester's item in its place, then holds off further grants until the tree
// has settled. Optional build macro: REGISTER_TREE_ARB_STATS_EN adds a 32-bit
// replace_count output counting ISSUE cycles since reset.
module register_tree_arbiter #(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned SETTLE_CYCLES = 3,
    parameter int unsigned INIT_CYCLES   = 4,
    parameter int unsigned ID_WIDTH      = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_item,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          resp_valid,
    output logic [DATA_WIDTH-1:0]         resp_item,
    output logic [ID_WIDTH-1:0]           resp_id,
    output logic                          tree_replace,
    output logic [DATA_WIDTH-1:0]         tree_new_item,
    input  logic [DATA_WIDTH-1:0]         tree_top_item,
    output logic                          busy
`ifdef REGISTER_TREE_ARB_STATS_EN
    ,
    output logic [31:0]                   replace_count
`endif
);

    // One shared down-counter serves both the INIT and SETTLE waits.
    localparam int unsigned CntMax = (INIT_CYCLES > SETTLE_CYCLES) ? INIT_CYCLES : SETTLE_CYCLES;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    typedef enum logic [1:0] {StInit, StIdle, StIssue, StSettle} state_e;

    state_e                  state_q, state_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]     winner;
    logic                    any_req;
    logic                    handshake;
    logic [DATA_WIDTH-1:0]   resp_item_q;
    logic [ID_WIDTH-1:0]     resp_id_q;
    logic [DATA_WIDTH-1:0]   new_item_q;
    logic [ID_WIDTH:0]       idx;

    // Round-robin search: first valid request at or after rr_ptr, wrapping.
    always_comb begin
        any_req = 1'b0;
        winner  = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (ID_WIDTH + 1)'(k);
            if (idx >= (ID_WIDTH + 1)'(NUM_REQ)) begin
                idx = idx - (ID_WIDTH + 1)'(NUM_REQ);
            end
            if (!any_req && req_valid[idx[ID_WIDTH-1:0]]) begin
                any_req = 1'b1;
                winner  = idx[ID_WIDTH-1:0];
            end
        end
    end

    assign handshake = (state_q == StIdle) && any_req;

    // Grant is combinational from req_valid, and only ever in IDLE.
    always_comb begin
        req_ready = '0;
        if (handshake) begin
            req_ready[winner] = 1'b1;
        end
    end

    // Next-state logic for the INIT/IDLE/ISSUE/SETTLE sequencer.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        unique case (state_q)
            StInit: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            StIdle: begin
                if (any_req) begin
                    state_d  = StIssue;
                    rr_ptr_d = (winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner + ID_WIDTH'(1);
                end
            end
            StIssue: begin
                cnt_d   = CntW'(SETTLE_CYCLES - 1);
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == '0) state_d = StIdle;
                else             cnt_d   = cnt_q - CntW'(1);
            end
            default: state_d = StInit;
        endcase
    end

    // State register; reset holds the INIT counter at its load value.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StInit;
            cnt_q    <= CntW'(INIT_CYCLES - 1);
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Capture the pushed item, the winner and the popped top at the handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            resp_item_q <= '0;
            resp_id_q   <= '0;
            new_item_q  <= '0;
        end else if (handshake) begin
            resp_item_q <= tree_top_item;
            resp_id_q   <= winner;
            new_item_q  <= req_item[winner*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign tree_replace  = (state_q == StIssue);
    assign resp_valid    = (state_q == StIssue);
    assign resp_item     = resp_item_q;
    assign resp_id       = resp_id_q;
    assign tree_new_item = new_item_q;
    assign busy          = (state_q != StIdle);

`ifdef REGISTER_TREE_ARB_STATS_EN
    logic [31:0] replace_count_q;

    // Count ISSUE cycles; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            replace_count_q <= '0;
        end else if (state_q == StIssue) begin
            replace_count_q <= replace_count_q + 32'd1;
        end
    end

    assign replace_count = replace_count_q;
`endif

endmodule

// File: tb/tb_register_tree_arbiter.sv
// Self-checking bench for register_tree_arbiter: a small register_tree model
// (max of an array) feeds tree_top_item, and a timing-level reference model
// predicts grants, responses and busy from cycle arithmetic.
module tb_register_tree_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DW      = 32;
    localparam int IDW     = 2;
    localparam int SETTLE  = 3;
    localparam int INIT    = 4;
    localparam int TREE_N  = 15;
    localparam int NCYC    = 800;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_REQ-1:0]      req_valid = '0;
    logic [NUM_REQ*DW-1:0]   req_item = '0;
    logic [NUM_REQ-1:0]      req_ready;
    logic                    resp_valid;
    logic [DW-1:0]           resp_item;
    logic [IDW-1:0]          resp_id;
    logic                    tree_replace;
    logic [DW-1:0]           tree_new_item;
    logic [DW-1:0]           tree_top_item = '0;
    logic                    busy;
`ifdef REGISTER_TREE_ARB_STATS_EN
    logic [31:0]             replace_count;
`endif

    always #5 clk = ~clk;

    register_tree_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_WIDTH   (DW),
        .SETTLE_CYCLES(SETTLE),
        .INIT_CYCLES  (INIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_item     (req_item),
        .req_ready    (req_ready),
        .resp_valid   (resp_valid),
        .resp_item    (resp_item),
        .resp_id      (resp_id),
        .tree_replace (tree_replace),
        .tree_new_item(tree_new_item),
        .tree_top_item(tree_top_item),
        .busy         (busy)
`ifdef REGISTER_TREE_ARB_STATS_EN
        ,
        .replace_count(replace_count)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // register_tree model: top is the maximum, replace overwrites the maximum.
    int tree [TREE_N];

    function automatic int tree_max_idx();
        int m = 0;
        for (int i = 1; i < TREE_N; i++) if (tree[i] > tree[m]) m = i;
        return m;
    endfunction

    // Requester side
    bit          pend [NUM_REQ];
    logic [DW-1:0] item [NUM_REQ];
    int          last_w = -1;

    // Reference model state
    bit          known = 1'b0;
    int          earliest = 0;
    int          issue_cycle = -1;
    int          rr = 0;
    logic [DW-1:0]  exp_resp_item = '0;
    logic [IDW-1:0] exp_resp_id = '0;
    logic [DW-1:0]  exp_new_item = '0;
    logic [31:0]    exp_count = '0;

    initial begin
        for (int i = 0; i < TREE_N; i++) tree[i] = (i + 1) * 10;
        tree_top_item = DW'(tree[tree_max_idx()]);
        for (int r = 0; r < NUM_REQ; r++) begin
            pend[r] = 1'b0;
            item[r] = '0;
        end

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            #1;
            // A handshake completes at the edge: that requester withdraws.
            if (last_w >= 0) begin
                pend[last_w] = 1'b0;
                last_w = -1;
            end
            if (c < 2) rst = 1'b1;
            else if (c >= 80 && $urandom_range(69) == 0) rst = 1'b1;
            else rst = 1'b0;

            for (int r = 0; r < NUM_REQ; r++) begin
                if (!pend[r]) begin
                    bit raise;
                    if (c < 20)      raise = (r == 0) && (c == 3);
                    else if (c < 80) raise = 1'b1;
                    else             raise = ($urandom_range(2) == 0);
                    if (raise) begin
                        pend[r] = 1'b1;
                        item[r] = (c == 3) ? DW'(42) : DW'($urandom_range(99));
                    end
                end
                req_valid[r]            = pend[r];
                req_item[r*DW +: DW]    = item[r];
            end

            @(negedge clk);
            begin
                bit                 exp_issue;
                logic [NUM_REQ-1:0] exp_ready;
                int                 w;
                exp_issue = (c == issue_cycle);
                exp_ready = '0;
                w = -1;
                if (c >= earliest) begin
                    for (int k = 0; k < NUM_REQ; k++) begin
                        if (w < 0 && pend[(rr + k) % NUM_REQ]) w = (rr + k) % NUM_REQ;
                    end
                end
                if (w >= 0) exp_ready[w] = 1'b1;

                if (known) begin
                    check("req_ready", 64'(req_ready), 64'(exp_ready));
                    check("resp_valid", 64'(resp_valid), 64'(exp_issue));
                    check("tree_replace", 64'(tree_replace), 64'(exp_issue));
                    check("busy", 64'(busy), 64'(c < earliest));
                    check("resp_item", 64'(resp_item), 64'(exp_resp_item));
                    check("resp_id", 64'(resp_id), 64'(exp_resp_id));
                    check("tree_new_item", 64'(tree_new_item), 64'(exp_new_item));
`ifdef REGISTER_TREE_ARB_STATS_EN
                    check("replace_count", 64'(replace_count), 64'(exp_count));
`endif
                end
                // Directed points from the opening single-request scenario.
                if (c == 5) check("t1_no_grant_early", 64'(req_ready), 64'(0));
                if (c == 6) check("t1_grant_req0", 64'(req_ready), 64'(1));
                if (c == 7) begin
                    check("t1_resp150", 64'(resp_item), 64'(150));
                    check("t1_push42", 64'(tree_new_item), 64'(42));
                    check("t1_replace", 64'(tree_replace), 64'(1));
                end

                // The tree sees every replace strobe, even one cut short by rst.
                if (exp_issue) begin
                    tree[tree_max_idx()] = int'(exp_new_item);
                    tree_top_item = DW'(tree[tree_max_idx()]);
                end

                if (rst) begin
                    known         = 1'b1;
                    earliest      = c + 1 + INIT;
                    issue_cycle   = -1;
                    rr            = 0;
                    exp_resp_item = '0;
                    exp_resp_id   = '0;
                    exp_new_item  = '0;
                    exp_count     = '0;
                end else begin
                    if (exp_issue) exp_count = exp_count + 32'd1;
                    if (w >= 0) begin
                        exp_new_item  = item[w];
                        exp_resp_id   = IDW'(w);
                        exp_resp_item = tree_top_item;
                        rr            = (w + 1) % NUM_REQ;
                        earliest      = c + 2 + SETTLE;
                        issue_cycle   = c + 1;
                    end
                end
                if (w >= 0) last_w = w;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
